// File: rtl/input_port_if.sv
// Purpose: link-side and allocator-side signals of one router input port.
// Latency: none (wiring only).
// Backpressure: credit return upstream; grant from the allocator pops the head flit.
interface input_port_if;
  logic [15:0] data_i;
  logic        valid_i;
  logic        inc_credit_o;
  logic [15:0] data_o;
  logic        req_o;
  logic [4:0]  req_port_o;
  logic        grant_i;
  logic        overflow_o;
  logic        proto_err_o;

  // Router side: receives flits and grants, drives credits, head flit and request.
  modport slave (
    input  data_i, valid_i, grant_i,
    output inc_credit_o, data_o, req_o, req_port_o, overflow_o, proto_err_o
  );

  // Environment side: upstream link plus switch allocator.
  modport master (
    output data_i, valid_i, grant_i,
    input  inc_credit_o, data_o, req_o, req_port_o, overflow_o, proto_err_o
  );
endinterface

// File: rtl/input_port.sv
// Purpose: credit-based flit buffer with XY route decode and per-packet allocator request.
// Latency: flit on data_o one edge after write; request one edge later; credit one edge after pop.
// Backpressure: upstream limited by DEPTH credits; writes while full are dropped and flagged.
module input_port #(
  parameter int         DEPTH = 5,
  parameter logic [3:0] X_ID  = 4'd0,
  parameter logic [3:0] Y_ID  = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input_port_if.slave  port
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q;
  state_t        state_d;
  logic [4:0]    route_q;
  logic [4:0]    route_d;
  logic          credit_q;
  logic          overflow_q;
  logic          proto_err_q;

  logic          empty;
  logic          full;
  logic [15:0]   head_flit;
  logic [1:0]    head_type;
  logic          req;
  logic          grant_pop;
  logic          discard_pop;
  logic          pop;
  logic          push;
  logic          drop;

  // XY routing: resolve X first, then Y; one-hot N,E,S,W,Local.
  function automatic logic [4:0] xy_route(input logic [7:0] dest);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = dest[7:4];
    dy = dest[3:0];
    if (dx > X_ID)      return 5'b00010;
    else if (dx < X_ID) return 5'b01000;
    else if (dy > Y_ID) return 5'b00001;
    else if (dy < Y_ID) return 5'b00100;
    else                return 5'b10000;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_flit = mem[rd_ptr_q];
  assign head_type = head_flit[15:14];

  // Packet FSM: in IDLE inspect the head flit, in ACTIVE request until the tail leaves.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    req         = 1'b0;
    grant_pop   = 1'b0;
    discard_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_type == T_HEAD || head_type == T_SINGLE) begin
            route_d = xy_route(head_flit[7:0]);
            state_d = ACTIVE;
          end else begin
            // Body/tail with no open packet: drop it but still return its credit.
            discard_pop = 1'b1;
          end
        end
      end
      ACTIVE: begin
        req = !empty;
        if (port.grant_i && req) begin
          grant_pop = 1'b1;
          if (head_type == T_TAIL || head_type == T_SINGLE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = grant_pop | discard_pop;
  // A full buffer still accepts a write when the same edge frees a slot.
  assign push = port.valid_i && (!full || pop);
  assign drop = port.valid_i && full && !pop;

  // State, route and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      route_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      credit_q <= pop;
      if (drop)        overflow_q  <= 1'b1;
      if (discard_pop) proto_err_q <= 1'b1;
    end
  end

  // Circular-buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Flit storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= port.data_i;
  end

  assign port.data_o       = empty ? 16'h0000 : head_flit;
  assign port.req_o        = req;
  assign port.req_port_o   = route_q;
  assign port.inc_credit_o = credit_q;
  assign port.overflow_o   = overflow_q;
  assign port.proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_input_port.sv
// Purpose: directed checks of buffering, XY routing, credits, errors and reset for input_port.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: grant withheld to fill the buffer and force an overflow.
module tb_input_port;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  input_port_if pif ();

  input_port #(.DEPTH(5), .X_ID(4'd1), .Y_ID(4'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pif.data_i = '0; pif.valid_i = 1'b0; pif.grant_i = 1'b0;
    tick(); tick();
    vectors++; if (pif.data_o !== 16'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0000", pif.data_o); end
    vectors++; if (pif.req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", pif.req_o); end
    vectors++; if (pif.req_port_o !== 5'b0) begin miscompares++; $display("FAIL rst_port: got %b want 00000", pif.req_port_o); end
    vectors++; if (pif.inc_credit_o !== 1'b0) begin miscompares++; $display("FAIL rst_credit: got %b want 0", pif.inc_credit_o); end
    vectors++; if (pif.overflow_o !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", pif.overflow_o); end
    vectors++; if (pif.proto_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_perr: got %b want 0", pif.proto_err_o); end
    rst_n = 1'b1;
    tick();
    vectors++; if (pif.req_o !== 1'b0 || pif.data_o !== 16'h0) begin miscompares++; $display("FAIL rst_release: got req %b data %h want 0 0000", pif.req_o, pif.data_o); end
  endtask

  task automatic test_single();
    pif.valid_i = 1'b1; pif.data_i = 16'hC021;
    tick();
    pif.valid_i = 1'b0;
    vectors++; if (pif.data_o !== 16'hC021) begin miscompares++; $display("FAIL single_data: got %h want c021", pif.data_o); end
    vectors++; if (pif.req_o !== 1'b0) begin miscompares++; $display("FAIL single_req_early: got %b want 0", pif.req_o); end
    tick();
    vectors++; if (pif.req_o !== 1'b1) begin miscompares++; $display("FAIL single_req: got %b want 1", pif.req_o); end
    vectors++; if (pif.req_port_o !== 5'b00010) begin miscompares++; $display("FAIL single_port: got %b want 00010", pif.req_port_o); end
    pif.grant_i = 1'b1;
    tick();
    pif.grant_i = 1'b0;
    vectors++; if (pif.inc_credit_o !== 1'b1) begin miscompares++; $display("FAIL single_credit: got %b want 1", pif.inc_credit_o); end
    vectors++; if (pif.req_o !== 1'b0 || pif.data_o !== 16'h0) begin miscompares++; $display("FAIL single_drain: got req %b data %h want 0 0000", pif.req_o, pif.data_o); end
    tick();
    vectors++; if (pif.inc_credit_o !== 1'b0) begin miscompares++; $display("FAIL single_credit_end: got %b want 0", pif.inc_credit_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data [4];
    int credits;
    exp_data[0] = 16'h0011; exp_data[1] = 16'h0022; exp_data[2] = 16'h8033; exp_data[3] = 16'h0000;
    credits = 0;
    pif.grant_i = 1'b1; pif.valid_i = 1'b1; pif.data_i = 16'h4010;
    tick();
    vectors++; if (pif.data_o !== 16'h4010 || pif.req_o !== 1'b0) begin miscompares++; $display("FAIL multi_head: got data %h req %b want 4010 0", pif.data_o, pif.req_o); end
    pif.data_i = 16'h0011;
    tick();
    vectors++; if (pif.req_o !== 1'b1 || pif.data_o !== 16'h4010 || pif.inc_credit_o !== 1'b0) begin miscompares++; $display("FAIL multi_req: got req %b data %h credit %b want 1 4010 0", pif.req_o, pif.data_o, pif.inc_credit_o); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) pif.data_i = 16'h0022;
      else if (i == 1) pif.data_i = 16'h8033;
      else pif.valid_i = 1'b0;
      vectors++; if (pif.req_port_o !== 5'b00100) begin miscompares++; $display("FAIL multi_port%0d: got %b want 00100", i, pif.req_port_o); end
      tick();
      if (pif.inc_credit_o === 1'b1) credits++;
      vectors++; if (pif.data_o !== exp_data[i]) begin miscompares++; $display("FAIL multi_data%0d: got %h want %h", i, pif.data_o, exp_data[i]); end
    end
    vectors++; if (credits != 4) begin miscompares++; $display("FAIL multi_credits: got %0d want 4", credits); end
    vectors++; if (pif.req_o !== 1'b0) begin miscompares++; $display("FAIL multi_req_drop: got %b want 0", pif.req_o); end
    pif.grant_i = 1'b0;
    tick();
    vectors++; if (pif.inc_credit_o !== 1'b0) begin miscompares++; $display("FAIL multi_credit_end: got %b want 0", pif.inc_credit_o); end
  endtask

  task automatic test_discard();
    pif.valid_i = 1'b1; pif.data_i = 16'h0123;
    tick();
    pif.valid_i = 1'b0;
    vectors++; if (pif.data_o !== 16'h0123 || pif.proto_err_o !== 1'b0) begin miscompares++; $display("FAIL disc_head: got data %h perr %b want 0123 0", pif.data_o, pif.proto_err_o); end
    tick();
    vectors++; if (pif.proto_err_o !== 1'b1) begin miscompares++; $display("FAIL disc_perr: got %b want 1", pif.proto_err_o); end
    vectors++; if (pif.inc_credit_o !== 1'b1) begin miscompares++; $display("FAIL disc_credit: got %b want 1", pif.inc_credit_o); end
    vectors++; if (pif.data_o !== 16'h0 || pif.req_o !== 1'b0) begin miscompares++; $display("FAIL disc_empty: got data %h req %b want 0000 0", pif.data_o, pif.req_o); end
    tick();
    vectors++; if (pif.inc_credit_o !== 1'b0 || pif.proto_err_o !== 1'b1 || pif.overflow_o !== 1'b0) begin miscompares++; $display("FAIL disc_after: got credit %b perr %b ovf %b want 0 1 0", pif.inc_credit_o, pif.proto_err_o, pif.overflow_o); end
  endtask

  task automatic test_overflow();
    logic [15:0] fill [5];
    logic [15:0] drain [5];
    fill[0] = 16'h4011; fill[1] = 16'h0012; fill[2] = 16'h0013; fill[3] = 16'h0014; fill[4] = 16'h0015;
    drain[0] = 16'h0012; drain[1] = 16'h0013; drain[2] = 16'h0014; drain[3] = 16'h0015; drain[4] = 16'h8077;
    pif.grant_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pif.valid_i = 1'b1; pif.data_i = fill[i];
      tick();
    end
    vectors++; if (dut.count_q !== 3'd5 || pif.overflow_o !== 1'b0) begin miscompares++; $display("FAIL ovf_fill: got count %0d ovf %b want 5 0", dut.count_q, pif.overflow_o); end
    vectors++; if (pif.req_o !== 1'b1 || pif.req_port_o !== 5'b10000) begin miscompares++; $display("FAIL local_route: got req %b port %b want 1 10000", pif.req_o, pif.req_port_o); end
    pif.data_i = 16'h0066;
    tick();
    vectors++; if (pif.overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", pif.overflow_o); end
    vectors++; if (dut.count_q !== 3'd5 || pif.data_o !== 16'h4011) begin miscompares++; $display("FAIL ovf_hold: got count %0d data %h want 5 4011", dut.count_q, pif.data_o); end
    pif.data_i = 16'h8077; pif.grant_i = 1'b1;
    tick();
    pif.valid_i = 1'b0;
    vectors++; if (dut.count_q !== 3'd5 || pif.inc_credit_o !== 1'b1 || pif.data_o !== 16'h0012) begin miscompares++; $display("FAIL ovf_pushpop: got count %0d credit %b data %h want 5 1 0012", dut.count_q, pif.inc_credit_o, pif.data_o); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (pif.data_o !== drain[i]) begin miscompares++; $display("FAIL ovf_drain%0d: got %h want %h", i, pif.data_o, drain[i]); end
      tick();
    end
    pif.grant_i = 1'b0;
    vectors++; if (pif.req_o !== 1'b0 || pif.data_o !== 16'h0) begin miscompares++; $display("FAIL ovf_empty: got req %b data %h want 0 0000", pif.req_o, pif.data_o); end
    tick();
    vectors++; if (pif.inc_credit_o !== 1'b0 || pif.overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got credit %b ovf %b want 0 1", pif.inc_credit_o, pif.overflow_o); end
  endtask

  task automatic test_west();
    pif.valid_i = 1'b1; pif.data_i = 16'hC003;
    tick();
    pif.valid_i = 1'b0;
    tick();
    vectors++; if (pif.req_o !== 1'b1 || pif.req_port_o !== 5'b01000) begin miscompares++; $display("FAIL west_route: got req %b port %b want 1 01000", pif.req_o, pif.req_port_o); end
    pif.grant_i = 1'b1;
    tick();
    pif.grant_i = 1'b0;
    vectors++; if (pif.inc_credit_o !== 1'b1 || pif.req_o !== 1'b0) begin miscompares++; $display("FAIL west_pop: got credit %b req %b want 1 0", pif.inc_credit_o, pif.req_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    pif.grant_i = 1'b0;
    pif.valid_i = 1'b1; pif.data_i = 16'h4020; tick();
    pif.data_i = 16'h0001; tick();
    pif.data_i = 16'h0002; tick();
    pif.valid_i = 1'b0;
    vectors++; if (dut.count_q !== 3'd3 || pif.req_o !== 1'b1 || pif.req_port_o !== 5'b00010) begin miscompares++; $display("FAIL mid_setup: got count %0d req %b port %b want 3 1 00010", dut.count_q, pif.req_o, pif.req_port_o); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({pif.data_o, pif.req_o, pif.req_port_o, pif.inc_credit_o, pif.overflow_o, pif.proto_err_o} !== 25'h0) begin miscompares++; $display("FAIL mid_rst_outputs: got data %h req %b port %b credit %b ovf %b perr %b want all 0", pif.data_o, pif.req_o, pif.req_port_o, pif.inc_credit_o, pif.overflow_o, pif.proto_err_o); end
    pif.grant_i = 1'b1;
    tick();
    vectors++; if (pif.inc_credit_o !== 1'b0 || dut.count_q !== 3'd0) begin miscompares++; $display("FAIL mid_rst_credit: got credit %b count %0d want 0 0", pif.inc_credit_o, dut.count_q); end
    pif.grant_i = 1'b0;
    rst_n = 1'b1;
    pif.valid_i = 1'b1; pif.data_i = 16'hC010;
    tick();
    pif.valid_i = 1'b0;
    tick();
    vectors++; if (pif.req_o !== 1'b1 || pif.req_port_o !== 5'b00100 || pif.data_o !== 16'hC010) begin miscompares++; $display("FAIL mid_after: got req %b port %b data %h want 1 00100 c010", pif.req_o, pif.req_port_o, pif.data_o); end
    pif.grant_i = 1'b1;
    tick();
    pif.grant_i = 1'b0;
    vectors++; if (pif.inc_credit_o !== 1'b1 || pif.req_o !== 1'b0) begin miscompares++; $display("FAIL mid_pop: got credit %b req %b want 1 0", pif.inc_credit_o, pif.req_o); end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_discard();
    test_overflow();
    test_west();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/input_port.md
# input_port

Receive side of the router's credit-based link: accepts 16-bit flits from the upstream output port, buffers them in a DEPTH-entry FIFO and returns one credit per flit removed. Decodes each packet's head flit with XY routing and requests the chosen output from the switch allocator. The request is held for the whole packet, through the tail flit. Sits between the link from a neighbouring router's output port and the crossbar/switch allocator.

## Interface
- DEPTH, 5: FIFO entries; equals the upstream output port's reset credit count.
- X_ID, 0: this router's X coordinate (4 bits).
- Y_ID, 0: this router's Y coordinate (4 bits).

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  16  flit from upstream.
- valid_i  input  1  upstream send strobe; write data_i this edge.
- inc_credit_o  output  1  one-cycle credit-return pulse to upstream.
- data_o  output  16  FIFO head flit; 0 when FIFO empty.
- req_o  output  1  requesting the crossbar for the head flit.
- req_port_o  output  5  one-hot target: bit0 N, bit1 E, bit2 S, bit3 W, bit4 Local.
- grant_i  input  1  allocator grant; pops the head flit this edge.
- overflow_o  output  1  sticky: write attempted while full.
- proto_err_o  output  1  sticky: non-head flit found at packet start.

## Operation
- Flit format: [15:14] type, 01 head, 00 body, 10 tail, 11 single (head+tail). On head/single flits, [7:4] is dest_x and [3:0] is dest_y.
- FIFO: circular buffer with a 3-bit occupancy count (0..DEPTH). Push on valid_i. Pop on a grant pop or a discard pop.
  - Push and pop in the same cycle: both take effect, including when full. Count is unchanged.
  - valid_i while full with no pop: flit dropped, overflow_o set.
- XY route, computed from the head flit:
  - dest_x > X_ID: E.
  - dest_x < X_ID: W.
  - Otherwise, dest_y > Y_ID: N; dest_y < Y_ID: S; equal: Local.
  - Comparisons are unsigned 4-bit.
- FSM states: IDLE, ACTIVE.
  - IDLE with FIFO empty: stay in IDLE.
  - IDLE, head is type head or single: latch route_q and go to ACTIVE.
  - IDLE, head is body or tail: discard-pop it, set proto_err_o, stay in IDLE.
  - ACTIVE: req_o = FIFO non-empty; req_port_o = route_q.
  - ACTIVE, grant_i && req_o: pop. If the popped flit is tail or single, go to IDLE; otherwise stay in ACTIVE.
  - grant_i while req_o=0: ignored.
- req_port_o holds route_q in both states. It is meaningful only when req_o=1.
- Credits: every pop (grant or discard) makes inc_credit_o high for exactly the next cycle. At most one pop per cycle, so back-to-back pops give back-to-back pulses.
- Reset (any time, including mid-packet):
  - FIFO empty, state IDLE, route_q 0.
  - All outputs 0: data_o, req_o, req_port_o, inc_credit_o, overflow_o, proto_err_o.
  - Buffered flits are lost without credit return. The upstream port must be reset at the same time.
- overflow_o and proto_err_o clear only on reset.

## Timing
- Flit written at edge N: visible on data_o after edge N.
- Head flit: route latched at edge N+1, req_o high after N+1. Grant in that cycle pops at edge N+2.
- inc_credit_o rises after the pop edge and falls one edge later.
- Body/tail flits already queued in ACTIVE: req_o stays high, allowing one flit per granted cycle.
- Discard pop in IDLE: occurs at the edge after the bad flit reaches the head.

## Test plan
- Single-flit packet: X_ID=1, Y_ID=1, send 0xC021 (dest 2,1).
  - req_o high 2 cycles after the write, req_port_o=00010 (E).
  - Grant pops it, inc_credit_o pulses once, FSM returns to IDLE.
- 4-flit packet with dest (1,0) at router (1,1), grant held high.
  - req_port_o=00100 (S) for all flits; 4 consecutive credit pulses.
  - req_o drops after the tail is popped.
- Grant withheld: push 5 flits, then a 6th with valid_i.
  - overflow_o=1, count stays 5, data_o is the first flit.
  - Grant once with a simultaneous push: count remains 5, one credit pulse.
- Body flit 0x0123 arriving in IDLE: discarded without req_o, proto_err_o=1, one credit pulse, FIFO empty.
- Local and W routes: dest (1,1) gives 10000; dest (0,3) gives 01000. Covers the dest_x < X_ID and equal-coordinate cases.
- rst_n asserted mid-packet with 3 flits queued.
  - Immediately: all outputs 0, no credit pulse.
  - After release: FSM is IDLE and the next head flit routes normally.
